// File: rtl/pipeline_mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter between IF and MEM.
package pipeline_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    START = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2,
    ADV   = 2'd3
  } arb_state_t;

  // addi x0,x0,0
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/pipeline_mem_arbiter_access_watchdog.sv
// Wait-cycle counter for one memory access; flags an abandon when the memory
// stays silent for TIMEOUT request cycles (TIMEOUT=0 never fires).
module pipeline_mem_arbiter_access_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic active,
  input  logic mem_ready,
  output logic timeout
);

  localparam int          CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic        EN   = (TIMEOUT > 0);

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (start) begin
      wait_cnt <= '0;
    end else if (active && !mem_ready) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  // mem_ready in the terminal cycle is a normal completion, not a timeout
  assign timeout = EN && active && !mem_ready && (wait_cnt == LAST);

endmodule

// File: rtl/pipeline_mem_arbiter.sv
// Sequences one optional data access then one fetch per pipeline advance on a
// single shared memory port, holding Stall until both are done.
//
// state | meaning
// START | idle cycle, pick DATA or FETCH from the MEM-stage op
// DATA  | load/store request outstanding
// FETCH | instruction fetch request outstanding
// ADV   | Stall low for one cycle, pipeline registers advance
module pipeline_mem_arbiter
  import pipeline_mem_arbiter_pkg::*;
#(
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_F,
  input  logic [31:0] ALUResult_M,
  input  logic [31:0] WriteData_M,
  input  logic        MemWrite_M,
  input  logic        MemRead_M,
  output logic [31:0] Instr_F,
  output logic [31:0] ReadData_M,
  output logic        Stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        bus_err,
  output logic [31:0] stall_cycles
);

  arb_state_t state;
  logic       timeout;
  logic       done;
  logic       wd_start;

  assign done     = mem_req && (mem_ready || timeout);
  assign wd_start = (state == START) || ((state == DATA) && done);

  pipeline_mem_arbiter_access_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .start     (wd_start),
    .active    (mem_req),
    .mem_ready (mem_ready),
    .timeout   (timeout)
  );

  // Request fields are snapshotted on entry; the frozen pipeline keeps the
  // source values stable anyway, so this matches a direct drive.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= START;
      Stall        <= 1'b1;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      Instr_F      <= NOP_INSTR;
      ReadData_M   <= '0;
      bus_err      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (Stall) stall_cycles <= stall_cycles + 32'd1;
      case (state)
        START: begin
          mem_req <= 1'b1;
          if (MemRead_M || MemWrite_M) begin
            state     <= DATA;
            mem_we    <= MemWrite_M;
            mem_addr  <= ALUResult_M;
            mem_wdata <= WriteData_M;
          end else begin
            state     <= FETCH;
            mem_we    <= 1'b0;
            mem_addr  <= PC_F;
            mem_wdata <= '0;
          end
        end
        DATA: begin
          if (done) begin
            if (MemRead_M) ReadData_M <= mem_ready ? mem_rdata : 32'd0;
            if (!mem_ready) bus_err <= 1'b1;
            state     <= FETCH;
            mem_we    <= 1'b0;
            mem_addr  <= PC_F;
            mem_wdata <= '0;
          end
        end
        FETCH: begin
          if (done) begin
            Instr_F <= mem_ready ? mem_rdata : NOP_INSTR;
            if (!mem_ready) bus_err <= 1'b1;
            state   <= ADV;
            mem_req <= 1'b0;
            Stall   <= 1'b0;
          end
        end
        ADV: begin
          state <= START;
          Stall <= 1'b1;
        end
        default: begin
          state   <= START;
          Stall   <= 1'b1;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Directed bench for pipeline_mem_arbiter with a variable-wait memory model.
module tb_pipeline_mem_arbiter;
  import pipeline_mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] PC_F = '0, ALUResult_M = '0, WriteData_M = '0;
  logic        MemWrite_M = 1'b0, MemRead_M = 1'b0;
  logic [31:0] Instr_F, ReadData_M, mem_addr, mem_wdata, mem_rdata, stall_cycles;
  logic        Stall, mem_req, mem_we, mem_ready, bus_err;

  int n_total = 0;
  int n_bad   = 0;

  // 255 = memory never answers
  int fetch_wait = 0;
  int data_wait  = 0;
  int wcnt = 0;
  logic [31:0] st_addr = '0, st_data = '0;
  int st_cnt = 0;

  pipeline_mem_arbiter #(.TIMEOUT(4), .NOP_INSTR(32'h0000_0013)) dut (
    .clk          (clk),
    .reset        (reset),
    .PC_F         (PC_F),
    .ALUResult_M  (ALUResult_M),
    .WriteData_M  (WriteData_M),
    .MemWrite_M   (MemWrite_M),
    .MemRead_M    (MemRead_M),
    .Instr_F      (Instr_F),
    .ReadData_M   (ReadData_M),
    .Stall        (Stall),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .bus_err      (bus_err),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0050_0093;
      32'h0000_0004: mem_word = 32'h0010_2183;
      32'h0000_0100: mem_word = 32'hDEAD_BEEF;
      default:       mem_word = a ^ 32'hA5A5_0000;
    endcase
  endfunction

  logic is_fetch;
  int   cur_wait;
  assign is_fetch  = (mem_addr == PC_F) && !mem_we;
  assign cur_wait  = is_fetch ? fetch_wait : data_wait;
  assign mem_ready = mem_req && (wcnt == cur_wait);
  assign mem_rdata = mem_word(mem_addr);

  always @(posedge clk) begin
    if (!mem_req || mem_ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (mem_req && mem_ready && mem_we) begin
      st_addr <= mem_addr;
      st_data <= mem_wdata;
      st_cnt  <= st_cnt + 1;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from START through ADV back to START.
  int          r_cyc, r_req, r_dstall;
  logic [31:0] f_addr, f_wdata, l_addr, adv_instr, adv_rdata;
  logic        f_we, l_we;

  task automatic run_instr(input logic [1:0] result_src, input logic wr,
                           input logic [31:0] alu, input logic [31:0] wd,
                           input logic [31:0] pc);
    int   ticks;
    logic seen_req;
    logic [31:0] sc0;
    MemRead_M   = (result_src == RESULT_SRC_LOAD);
    MemWrite_M  = wr;
    ALUResult_M = alu;
    WriteData_M = wd;
    PC_F        = pc;
    sc0      = stall_cycles;
    ticks    = 0;
    r_req    = 0;
    seen_req = 1'b0;
    do begin
      tick();
      ticks++;
      if (mem_req) begin
        r_req++;
        if (!seen_req) begin
          f_addr = mem_addr; f_we = mem_we; f_wdata = mem_wdata;
          seen_req = 1'b1;
        end
        l_addr = mem_addr; l_we = mem_we;
      end
    end while (Stall && ticks < 40);
    if (ticks >= 40) chk_eq("adv_bound", 32'd0, 32'd1);
    r_cyc     = ticks + 1;
    adv_instr = Instr_F;
    adv_rdata = ReadData_M;
    tick();
    r_dstall  = int'(stall_cycles - sc0);
  endtask

  initial begin
    reset = 1'b0;
    tick(); tick();
    chk_eq("rst_stall",   32'(Stall), 32'd1);
    chk_eq("rst_req",     32'(mem_req), 32'd0);
    chk_eq("rst_we",      32'(mem_we), 32'd0);
    chk_eq("rst_instr",   Instr_F, 32'h0000_0013);
    chk_eq("rst_rdata",   ReadData_M, 32'd0);
    chk_eq("rst_buserr",  32'(bus_err), 32'd0);
    chk_eq("rst_scyc",    stall_cycles, 32'd0);
    reset = 1'b1;

    // plain ALU instruction, zero-wait
    run_instr(2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
    chk_eq("add_cyc",    32'(r_cyc), 32'd3);
    chk_eq("add_req",    32'(r_req), 32'd1);
    chk_eq("add_addr",   f_addr, 32'h0);
    chk_eq("add_instr",  adv_instr, 32'h0050_0093);
    chk_eq("add_dstall", 32'(r_dstall), 32'd2);

    // load with two wait states on the data access
    data_wait = 2;
    run_instr(2'b01, 1'b0, 32'h100, 32'h0, 32'h4);
    chk_eq("lw_cyc",    32'(r_cyc), 32'd6);
    chk_eq("lw_req",    32'(r_req), 32'd4);
    chk_eq("lw_daddr",  f_addr, 32'h100);
    chk_eq("lw_dwe",    32'(f_we), 32'd0);
    chk_eq("lw_faddr",  l_addr, 32'h4);
    chk_eq("lw_rdata",  adv_rdata, 32'hDEAD_BEEF);
    chk_eq("lw_instr",  adv_instr, 32'h0010_2183);
    chk_eq("lw_dstall", 32'(r_dstall), 32'd5);

    // store, zero-wait
    data_wait = 0;
    run_instr(2'b00, 1'b1, 32'h200, 32'h1234_5678, 32'h8);
    chk_eq("sw_cyc",    32'(r_cyc), 32'd4);
    chk_eq("sw_addr",   f_addr, 32'h200);
    chk_eq("sw_we",     32'(f_we), 32'd1);
    chk_eq("sw_wdata",  f_wdata, 32'h1234_5678);
    chk_eq("sw_faddr",  l_addr, 32'h8);
    chk_eq("sw_fwe",    32'(l_we), 32'd0);
    chk_eq("sw_rdata",  adv_rdata, 32'hDEAD_BEEF);
    chk_eq("sw_mdata",  st_data, 32'h1234_5678);
    chk_eq("sw_mcnt",   32'(st_cnt), 32'd1);

    // fetch that never completes
    fetch_wait = 255;
    run_instr(2'b00, 1'b0, 32'h0, 32'h0, 32'hC);
    chk_eq("to_req",    32'(r_req), 32'd4);
    chk_eq("to_cyc",    32'(r_cyc), 32'd6);
    chk_eq("to_instr",  adv_instr, 32'h0000_0013);
    chk_eq("to_buserr", 32'(bus_err), 32'd1);

    fetch_wait = 0;
    run_instr(2'b00, 1'b0, 32'h0, 32'h0, 32'h10);
    chk_eq("post_buserr", 32'(bus_err), 32'd1);
    chk_eq("post_instr",  adv_instr, 32'h10 ^ 32'hA5A5_0000);

    // reset while a load is waiting
    MemRead_M = 1'b1; MemWrite_M = 1'b0; ALUResult_M = 32'h100; PC_F = 32'h0;
    data_wait = 255;
    tick(); tick();
    chk_eq("mid_req_before", 32'(mem_req), 32'd1);
    reset = 1'b0;
    tick();
    chk_eq("mid_req",    32'(mem_req), 32'd0);
    chk_eq("mid_stall",  32'(Stall), 32'd1);
    chk_eq("mid_scyc",   stall_cycles, 32'd0);
    chk_eq("mid_buserr", 32'(bus_err), 32'd0);
    reset = 1'b1;
    data_wait = 0;
    run_instr(2'b01, 1'b0, 32'h100, 32'h0, 32'h0);
    chk_eq("mid_cyc",    32'(r_cyc), 32'd4);
    chk_eq("mid_rdata",  adv_rdata, 32'hDEAD_BEEF);
    chk_eq("mid_dstall", 32'(r_dstall), 32'd3);

    // ready lands in the terminal wait cycle
    fetch_wait = 3;
    run_instr(2'b00, 1'b0, 32'h0, 32'h0, 32'h14);
    chk_eq("edge_req",    32'(r_req), 32'd4);
    chk_eq("edge_instr",  adv_instr, 32'h14 ^ 32'hA5A5_0000);
    chk_eq("edge_buserr", 32'(bus_err), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
